// File: rtl/paddle_sprite_gen.sv
// Pipelined paddle sprite renderer: frame-latched position, 2-cycle color path.
// Define PADDLE_FLASH_EN to build the hit-flash border animation.
module paddle_sprite_gen #(
  parameter int          PAD_W        = 101,
  parameter int          PAD_H        = 75,
  parameter int          BORDER       = 4,
  parameter logic [2:0]  COLOR_EDGE   = 3'h2,
  parameter logic [2:0]  COLOR_FILL   = 3'h5,
  parameter logic [2:0]  COLOR_FLASH  = 3'h7,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [15:0] x_loc,
  input  logic [15:0] y_loc,
  input  logic        pix_valid,
  input  logic [15:0] pixel_x,
  input  logic [15:0] pixel_y,
  input  logic        hit,
  output logic        color_valid,
  output logic [2:0]  color,
  output logic        flashing
);

  localparam logic signed [16:0] DX_MAX = 17'(PAD_W - 1);
  localparam logic signed [16:0] DY_MAX = 17'(PAD_H - 1);
  localparam logic [15:0]        W_M1   = 16'(PAD_W - 1);
  localparam logic [15:0]        H_M1   = 16'(PAD_H - 1);
  localparam logic [15:0]        BRD    = 16'(BORDER);
  localparam logic [15:0]        BRD_M1 = 16'(BORDER - 1);

  function automatic logic [2:0] pix_color(input logic [15:0] dx, input logic [15:0] dy,
                                           input logic parity, input logic flash_on);
    logic [15:0] dist_x;
    logic [15:0] dist_y;
    logic        is_border;
    logic        is_cut;
    dist_x    = (dx <= W_M1 - dx) ? dx : W_M1 - dx;
    dist_y    = (dy <= H_M1 - dy) ? dy : H_M1 - dy;
    is_border = (dist_x < BRD) || (dist_y < BRD);
    is_cut    = (dist_x < BRD) && (dist_y < BRD) && (dist_x + dist_y < BRD_M1);
    if (is_cut)
      pix_color = 3'h0;
    else if (is_border)
      pix_color = flash_on ? COLOR_FLASH : COLOR_EDGE;
    else
      pix_color = parity ? COLOR_FILL : 3'h0;
  endfunction

  logic [15:0] x_q, y_q;
  logic [15:0] x_cur, y_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (frame_start) begin
      x_q <= x_loc;
      y_q <= y_loc;
    end
  end

  // A pixel arriving with frame_start already sees the new position
  assign x_cur = frame_start ? x_loc : x_q;
  assign y_cur = frame_start ? y_loc : y_q;

  logic flash_on;

`ifdef PADDLE_FLASH_EN
  typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} state_t;
  localparam logic [7:0] CNT_LOAD = 8'(FLASH_FRAMES);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A hit always reloads, taking priority over a coincident frame decrement
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nx = FLASH;
          cnt_nx   = CNT_LOAD;
        end
      end
      FLASH: begin
        if (hit) begin
          cnt_nx = CNT_LOAD;
        end else if (frame_start) begin
          if (cnt == 8'd1) state_nx = IDLE;
          cnt_nx = cnt - 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    flashing = 1'b0;
    flash_on = 1'b0;
    if (state == FLASH) begin
      flashing = 1'b1;
      flash_on = cnt[0];
    end
  end
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign flashing   = 1'b0;
  assign flash_on   = 1'b0;
`endif

  // Stage 0 -> 1: offsets from paddle origin and box test
  logic signed [16:0] dx_p0, dy_p0;
  logic               in_box_p0, parity_p0;

  assign dx_p0     = $signed({1'b0, pixel_x}) - $signed({1'b0, x_cur});
  assign dy_p0     = $signed({1'b0, pixel_y}) - $signed({1'b0, y_cur});
  assign in_box_p0 = !dx_p0[16] && !dy_p0[16] && (dx_p0 <= DX_MAX) && (dy_p0 <= DY_MAX);
  assign parity_p0 = pixel_x[0] ~^ pixel_y[0];

  logic [15:0] dx_p1, dy_p1;
  logic        in_box_p1, parity_p1, vld_p1;

  always_ff @(posedge clk) begin
    dx_p1     <= dx_p0[15:0];
    dy_p1     <= dy_p0[15:0];
    in_box_p1 <= in_box_p0;
    parity_p1 <= parity_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= pix_valid;
  end

  // Stage 1 -> 2: color lookup, flash state sampled alongside the pixel
  logic [2:0] color_p2;
  logic       vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_p2 <= 3'h0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2   <= vld_p1;
      color_p2 <= (vld_p1 && in_box_p1) ? pix_color(dx_p1, dy_p1, parity_p1, flash_on) : 3'h0;
    end
  end

  assign color       = color_p2;
  assign color_valid = vld_p2;

endmodule

// File: tb/tb_paddle_sprite_gen.sv
// Randomized and directed bench for paddle_sprite_gen against a frame/pixel-level model.
// Honours PADDLE_FLASH_EN the same way as the design.
module tb_paddle_sprite_gen;

  localparam int PAD_W = 101;
  localparam int PAD_H = 75;
  localparam int BORDER = 4;
  localparam int FLASH_FRAMES = 8;
`ifdef PADDLE_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [15:0] x_loc = '0, y_loc = '0;
  logic        pix_valid = 1'b0;
  logic [15:0] pixel_x = '0, pixel_y = '0;
  logic        hit = 1'b0;
  logic        color_valid;
  logic [2:0]  color;
  logic        flashing;

  paddle_sprite_gen dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .x_loc(x_loc), .y_loc(y_loc),
    .pix_valid(pix_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .hit(hit),
    .color_valid(color_valid), .color(color), .flashing(flashing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: latched position, frames of flash remaining, one pending result
  int         mx = 0, my = 0, fl = 0;
  logic       p1_v = 1'b0, out_v = 1'b0;
  logic [2:0] p1_c = 3'h0, out_c = 3'h0;
  logic [15:0] cur_xl = '0, cur_yl = '0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [2:0] ref_color(input int px, input int py, input int ox,
                                           input int oy, input int left);
    int rx, ry, ex, ey;
    rx = px - ox;
    ry = py - oy;
    if (rx < 0 || rx >= PAD_W || ry < 0 || ry >= PAD_H) return 3'h0;
    ex = imin(rx, PAD_W - 1 - rx);
    ey = imin(ry, PAD_H - 1 - ry);
    if (ex < BORDER && ey < BORDER && ex + ey < BORDER - 1) return 3'h0;
    if (ex < BORDER || ey < BORDER) return (left > 0 && (left % 2) == 1) ? 3'h7 : 3'h2;
    return ((px % 2) == (py % 2)) ? 3'h5 : 3'h0;
  endfunction

  task automatic step(input logic fs, input logic [15:0] xl, input logic [15:0] yl,
                      input logic pv, input logic [15:0] px, input logic [15:0] py,
                      input logic h);
    frame_start = fs; x_loc = xl; y_loc = yl;
    pix_valid = pv; pixel_x = px; pixel_y = py; hit = h;
    @(posedge clk);
    if (fs) begin mx = int'(xl); my = int'(yl); end
    if (FLASH_EN) begin
      if (h) fl = FLASH_FRAMES;
      else if (fs && fl > 0) fl--;
    end
    out_v = p1_v;
    out_c = p1_c;
    p1_v  = pv;
    p1_c  = pv ? ref_color(int'(px), int'(py), mx, my, fl) : 3'h0;
    #1;
    check_val("color_valid", 16'(color_valid), 16'(out_v));
    check_val("color", 16'(color), 16'(out_c));
    check_val("flashing", 16'(flashing), 16'(fl > 0));
  endtask

  task automatic idle();
    step(1'b0, cur_xl, cur_yl, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic new_frame(input logic [15:0] xl, input logic [15:0] yl);
    cur_xl = xl; cur_yl = yl;
    step(1'b1, xl, yl, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic probe(input string tag, input logic [15:0] px, input logic [15:0] py,
                       input logic [2:0] exp);
    step(1'b0, cur_xl, cur_yl, 1'b1, px, py, 1'b0);
    idle();
    check_val(tag, 16'(color), 16'(exp));
  endtask

  initial begin
    #1;
    check_val("rst_color", 16'(color), 16'h0);
    check_val("rst_color_valid", 16'(color_valid), 16'h0);
    check_val("rst_flashing", 16'(flashing), 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic rendering at (100,50)
    new_frame(16'd100, 16'd50);
    probe("corner_cut", 16'd100, 16'd50, 3'h0);
    probe("top_edge", 16'd103, 16'd50, 3'h2);
    probe("fill_on", 16'd150, 16'd80, 3'h5);
    probe("fill_off", 16'd151, 16'd80, 3'h0);
    probe("right_out", 16'd201, 16'd80, 3'h0);
    probe("bottom_out", 16'd150, 16'd125, 3'h0);
    probe("right_edge", 16'd200, 16'd80, 3'h2);
    probe("bottom_edge", 16'd150, 16'd124, 3'h2);

    // Position change without frame_start must not move the paddle
    cur_xl = 16'd300;
    probe("no_tear_old", 16'd103, 16'd50, 3'h2);
    probe("no_tear_new", 16'd303, 16'd50, 3'h0);
    new_frame(16'd300, 16'd50);
    probe("moved_new", 16'd303, 16'd50, 3'h2);
    probe("moved_old", 16'd103, 16'd50, 3'h0);

    // No wraparound near the top of the coordinate space
    new_frame(16'hFFF0, 16'd50);
    probe("no_wrap", 16'd3, 16'd60, 3'h0);
    probe("high_edge", 16'hFFF0, 16'd60, 3'h2);
    new_frame(16'd300, 16'd50);

`ifdef PADDLE_FLASH_EN
    step(1'b0, cur_xl, cur_yl, 1'b0, 16'h0, 16'h0, 1'b1);
    probe("flash_start", 16'd303, 16'd50, 3'h2);
    for (int k = 1; k <= FLASH_FRAMES; k++) begin
      new_frame(16'd300, 16'd50);
      probe("flash_frame", 16'd303, 16'd50,
            (k < FLASH_FRAMES && ((FLASH_FRAMES - k) % 2) == 1) ? 3'h7 : 3'h2);
      check_val("flash_active", 16'(flashing), 16'(k < FLASH_FRAMES));
    end
    step(1'b0, cur_xl, cur_yl, 1'b0, 16'h0, 16'h0, 1'b1);
    for (int k = 1; k < FLASH_FRAMES; k++) new_frame(16'd300, 16'd50);
    step(1'b1, 16'd300, 16'd50, 1'b0, 16'h0, 16'h0, 1'b1);
    check_val("reload_flashing", 16'(flashing), 16'h1);
    probe("reload_even", 16'd303, 16'd50, 3'h2);
    new_frame(16'd300, 16'd50);
    probe("reload_odd", 16'd303, 16'd50, 3'h7);
    for (int k = 1; k < FLASH_FRAMES; k++) new_frame(16'd300, 16'd50);
`else
    step(1'b0, cur_xl, cur_yl, 1'b0, 16'h0, 16'h0, 1'b1);
    check_val("hit_ignored", 16'(flashing), 16'h0);
    probe("edge_no_flash", 16'd303, 16'd50, 3'h2);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic fs, h, pv;
      logic [15:0] xl, yl, px, py;
      fs = ($urandom_range(0, 39) == 0);
      h  = ($urandom_range(0, 59) == 0);
      pv = ($urandom_range(0, 3) != 0);
      xl = ($urandom_range(0, 7) == 0) ? 16'(16'hFFC0 + $urandom_range(0, 63))
                                       : 16'($urandom_range(0, 600));
      yl = 16'($urandom_range(0, 400));
      if (fs) begin cur_xl = xl; cur_yl = yl; end
      px = 16'(mx + $urandom_range(0, PAD_W + 15) - 8);
      py = 16'(my + $urandom_range(0, PAD_H + 15) - 8);
      step(fs, xl, yl, pv, px, py, h);
    end

    // Asynchronous reset with valid pixels in flight
    new_frame(16'd100, 16'd50);
    step(1'b0, cur_xl, cur_yl, 1'b1, 16'd103, 16'd50, 1'b1);
    step(1'b0, cur_xl, cur_yl, 1'b1, 16'd150, 16'd80, 1'b0);
    pix_valid = 1'b0; hit = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("async_color_valid", 16'(color_valid), 16'h0);
    check_val("async_color", 16'(color), 16'h0);
    check_val("async_flashing", 16'(flashing), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mx = 0; my = 0; fl = 0;
    p1_v = 1'b0; p1_c = 3'h0;
    cur_xl = 16'd0; cur_yl = 16'd0;
    idle();
    probe("post_rst_origin", 16'd3, 16'd5, 3'h2);
    probe("post_rst_old_pos", 16'd103, 16'd50, 3'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
